// File: rtl/sine_gen_pkg.sv
// Shared definitions for the sine stream generator.
//   - quarter-wave table builder evaluated at elaboration time
//   - mid-scale helper for offset-binary samples
//   - control state encoding
package sine_gen_pkg;

    // Table entries sit on a fixed 16-bit stride so a single packed constant
    // can carry any supported geometry (DATA_W <= 17, ADDR_W <= 10).
    localparam int ENTRY_W     = 16;
    localparam int MAX_ENTRIES = 256;
    localparam int TBL_BITS    = ENTRY_W * MAX_ENTRIES;

    localparam real PI = 3.14159265358979323846;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // Mid-scale code of an offset-binary sample of width data_w.
    function automatic int mid_value(input int data_w);
        return 32'sd1 <<< (data_w - 1);
    endfunction

    // q[i] = round((2^(data_w-1)-1) * sin(2*pi*(i+0.5)/2^addr_w)) for the first
    // quarter period. Samples are taken at bin centres, so the quarter is
    // mirror-symmetric and the other three quadrants are pure folds of it.
    function automatic logic [TBL_BITS-1:0] build_quarter_table(input int data_w,
                                                                input int addr_w);
        logic [TBL_BITS-1:0] tbl;
        real                 peak;
        real                 ang;
        real                 val;
        int                  depth;
        tbl   = '0;
        depth = 1 << (addr_w - 2);
        peak  = real'((1 << (data_w - 1)) - 1);
        for (int i = 0; i < depth; i++) begin
            ang = 2.0 * PI * (real'(i) + 0.5) / real'(1 << addr_w);
            val = peak * $sin(ang);
            tbl[i*ENTRY_W +: ENTRY_W] = 16'($rtoi(val + 0.5));
        end
        return tbl;
    endfunction

endpackage

// File: rtl/sine_quarter_rom.sv
// Quarter-wave sine ROM with a registered read port.
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   en_i           : read enable (pipeline advance)
//   addr_i         : quarter-table index, ADDR_W-2 bits
//   data_o         : registered magnitude, DATA_W-1 bits
module sine_quarter_rom
    import sine_gen_pkg::*;
#(
    parameter int DATA_W = 12,
    parameter int ADDR_W = 6
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              en_i,
    input  logic [ADDR_W-3:0] addr_i,
    output logic [DATA_W-2:0] data_o
);

    localparam logic [TBL_BITS-1:0] TABLE = build_quarter_table(DATA_W, ADDR_W);

    logic [DATA_W-2:0] data_q;

    // Registered table lookup; holds while the pipeline is stalled.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            data_q <= '0;
        end else if (en_i) begin
            data_q <= TABLE[{addr_i, 4'b0000} +: (DATA_W - 1)];
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/sine_stream_gen.sv
// Programmable sine stream generator.
// A phase accumulator addresses per-lane quarter-wave ROMs; each output beat
// carries LANES consecutive samples, lane 0 in the most significant bits.
//   clk, rst_n          : clock, asynchronous active-low reset
//   start / stop        : run control pulses
//   step, phase_offset  : phase increment per sample / initial phase
//   amp_shift           : attenuation as a right shift of the magnitude
//   burst_len           : beats per run, 0 = continuous
//   busy, done          : run in progress / one-cycle completion pulse
//   m_valid, m_ready, m_data : output stream
module sine_stream_gen
    import sine_gen_pkg::*;
#(
    parameter int DATA_W   = 12,
    parameter int SAMPLE_W = 16,
    parameter int ADDR_W   = 6,
    parameter int PHASE_W  = 16,
    parameter int LANES    = 4,
    parameter int COUNT_W  = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      stop,
    input  logic [PHASE_W-1:0]        step,
    input  logic [PHASE_W-1:0]        phase_offset,
    input  logic [1:0]                amp_shift,
    input  logic [COUNT_W-1:0]        burst_len,
    output logic                      busy,
    output logic                      done,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [LANES*SAMPLE_W-1:0] m_data
);

    localparam int                IDX_W = ADDR_W - 2;
    localparam logic [DATA_W-1:0] MID_C = DATA_W'(mid_value(DATA_W));

    // ------------------------------------------------------------------
    // Reset: asserted asynchronously, released on a clock edge.
    // ------------------------------------------------------------------
    logic [1:0] rst_sync_q;
    logic       rst_int_n;

    // Two-flop release synchroniser for the internal reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync_q[1];

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    state_e               state_q, state_d;
    logic [PHASE_W-1:0]   acc_q, acc_d;
    logic [PHASE_W-1:0]   step_q, step_d;
    logic [COUNT_W-1:0]   cnt_q, cnt_d;
    logic [COUNT_W-1:0]   burst_q, burst_d;
    logic [1:0]           amp_q, amp_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic                 v1_q, v2_q, m_valid_q;
    logic [LANES*SAMPLE_W-1:0] m_data_q;

    logic                 pipe_en_s;
    logic                 drained_s;
    logic                 issue_s;
    logic [COUNT_W-1:0]   cnt_inc_s;

    // One shared advance for every stage: only a refused output beat stalls.
    assign pipe_en_s = ~(m_valid_q & ~m_ready);
    // Nothing left in flight once the output register empties this cycle.
    assign drained_s = ~v1_q & ~v2_q & (~m_valid_q | m_ready);
    assign cnt_inc_s = cnt_q + COUNT_W'(1);

    // Control state registers.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            step_q  <= '0;
            cnt_q   <= '0;
            burst_q <= '0;
            amp_q   <= 2'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
            burst_q <= burst_d;
            amp_q   <= amp_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic: run control, beat issue and accumulator update.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        step_d  = step_q;
        cnt_d   = cnt_q;
        burst_d = burst_q;
        amp_d   = amp_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        issue_s = 1'b0;
        case (state_q)
            IDLE: begin
                // start wins over a simultaneous stop; stop alone is ignored
                if (start) begin
                    state_d = RUN;
                    acc_d   = phase_offset;
                    step_d  = step;
                    burst_d = burst_len;
                    amp_d   = amp_shift;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = DRAIN;
                end else if (pipe_en_s) begin
                    issue_s = 1'b1;
                    acc_d   = acc_q + PHASE_W'(LANES) * step_q;
                    cnt_d   = cnt_inc_s;
                    if ((burst_q != '0) && (cnt_inc_s == burst_q)) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = RUN;
                    end
                end else begin
                    state_d = RUN;
                end
            end
            DRAIN: begin
                if (drained_s) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d = DRAIN;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Stage 1: lane phases -> folded table index and sign
    // ------------------------------------------------------------------
    logic [PHASE_W-1:0] ph_s    [LANES];
    logic [IDX_W-1:0]   addr_s  [LANES];
    logic               neg_s   [LANES];
    logic [IDX_W-1:0]   addr1_q [LANES];
    logic               neg1_q  [LANES];
    logic               neg2_q  [LANES];
    logic [DATA_W-2:0]  rom_s   [LANES];
    logic [DATA_W-1:0]  mag_s   [LANES];
    logic [DATA_W-1:0]  smp_s   [LANES];
    logic [LANES*SAMPLE_W-1:0] data_s;

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        assign ph_s[j] = acc_q + PHASE_W'(j) * step_q;
        // Odd quadrants walk the quarter table backwards: Q-1-i == ~i.
        assign addr_s[j] = ph_s[j][PHASE_W-2]
                         ? ~ph_s[j][PHASE_W-3 -: IDX_W]
                         :  ph_s[j][PHASE_W-3 -: IDX_W];
        // Quadrants 2 and 3 form the negative half-cycle.
        assign neg_s[j] = ph_s[j][PHASE_W-1];

        if (PHASE_W > ADDR_W) begin : g_lsb
            logic unused_lsb_s;
            assign unused_lsb_s = ^ph_s[j][PHASE_W-ADDR_W-1:0];
        end

        sine_quarter_rom #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W)
        ) u_rom (
            .clk_i   (clk),
            .rst_n_i (rst_int_n),
            .en_i    (pipe_en_s),
            .addr_i  (addr1_q[j]),
            .data_o  (rom_s[j])
        );

        // Negative half mirrors around MID-1 so the waveform stays symmetric.
        assign mag_s[j] = {1'b0, rom_s[j]} >> amp_q;
        assign smp_s[j] = neg2_q[j] ? (MID_C - DATA_W'(1) - mag_s[j])
                                    : (MID_C + mag_s[j]);
        assign data_s[(LANES-1-j)*SAMPLE_W +: SAMPLE_W] = SAMPLE_W'(smp_s[j]);
    end

    // Stage 1 and stage 2 side-band registers (ROM holds stage 2 data).
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            for (int j = 0; j < LANES; j++) begin
                addr1_q[j] <= '0;
                neg1_q[j]  <= 1'b0;
                neg2_q[j]  <= 1'b0;
            end
        end else if (pipe_en_s) begin
            v1_q <= issue_s;
            v2_q <= v1_q;
            for (int j = 0; j < LANES; j++) begin
                addr1_q[j] <= addr_s[j];
                neg1_q[j]  <= neg_s[j];
                neg2_q[j]  <= neg1_q[j];
            end
        end
    end

    // Stage 3: packed output beat register.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
        end else if (pipe_en_s) begin
            m_valid_q <= v2_q;
            m_data_q  <= data_s;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;

endmodule

// File: tb/tb_sine_stream_gen.sv
module tb_sine_stream_gen;

    localparam real PI = 3.14159265358979323846;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, stop;
    logic [15:0] step, phase_offset;
    logic [1:0]  amp_shift;
    logic [15:0] burst_len;
    logic        busy, done, m_valid, m_ready;
    logic [63:0] m_data;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int done_cnt = 0;

    logic [63:0] exp_q[$];
    logic [63:0] rx_q[$];

    always #5 clk = ~clk;

    sine_stream_gen dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .stop         (stop),
        .step         (step),
        .phase_offset (phase_offset),
        .amp_shift    (amp_shift),
        .burst_len    (burst_len),
        .busy         (busy),
        .done         (done),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Full-period reference: sample k of 64 straight from sin(), no folding.
    function automatic logic [15:0] model_sample(input logic [15:0] ph, input logic [1:0] sh);
        int          k;
        int          a;
        real         r;
        logic [11:0] v;
        k = int'(ph[15:10]);
        r = 2047.0 * $sin(2.0 * PI * (real'(k) + 0.5) / 64.0);
        if (r >= 0.0) begin
            a = $rtoi(r + 0.5);
            v = 12'(2048 + (a >> sh));
        end else begin
            a = $rtoi(0.5 - r);
            v = 12'(2047 - (a >> sh));
        end
        return {4'h0, v};
    endfunction

    function automatic logic [63:0] model_beat(input logic [15:0] off, input logic [15:0] st,
                                               input logic [1:0] sh, input int k);
        logic [63:0] b;
        logic [15:0] ph;
        for (int j = 0; j < 4; j++) begin
            ph = off + 16'(k * 4 + j) * st;
            b[(3 - j) * 16 +: 16] = model_sample(ph, sh);
        end
        return b;
    endfunction

    // Output monitor / scoreboard, sampled away from the active edge.
    always @(negedge clk) begin
        if (rst_n && done) done_cnt++;
        if (rst_n && m_valid && m_ready) begin
            rx_q.push_back(m_data);
            if (exp_q.size() == 0) begin
                chk_cnt++;
                $display("FAIL unexpected_beat: got 0x%0h expected no beat", m_data);
            end else begin
                check("beat_data", m_data, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic configure(input logic [15:0] st, input logic [15:0] off,
                             input logic [1:0] sh, input logic [15:0] len, input int n_exp);
        step = st; phase_offset = off; amp_shift = sh; burst_len = len;
        rx_q.delete();
        exp_q.delete();
        for (int k = 0; k < n_exp; k++) exp_q.push_back(model_beat(off, st, sh, k));
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int c;
        c = 0;
        while (!done && c < budget) begin tick(); c++; end
        chk_cnt++;
        if (done) pass_cnt++;
        else $display("FAIL %s: done got 0 within %0d cycles expected 1", name, budget);
    endtask

    task automatic wait_rx(input int n, input int budget, input string name);
        int c;
        c = 0;
        while (rx_q.size() < n && c < budget) begin tick(); c++; end
        check(name, 64'(rx_q.size() >= n), 64'd1);
    endtask

    typedef struct {
        logic [15:0] st;
        logic [15:0] off;
        logic [1:0]  sh;
        int          beat;
        logic [15:0] lane0;
    } vec_t;

    vec_t vecs[9];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          c;
        int          rx_at_stop;
        int          dc;
        logic [63:0] got;
        logic [63:0] held_exp;

        vecs[0] = '{16'h0400, 16'h0000, 2'd0,  0, 16'h0864};
        vecs[1] = '{16'h0400, 16'h0000, 2'd0,  4, 16'd4093};
        vecs[2] = '{16'h0400, 16'h0000, 2'd0,  8, 16'd1947};
        vecs[3] = '{16'h0400, 16'h0000, 2'd0, 12, 16'd2};
        vecs[4] = '{16'h0400, 16'h0000, 2'd0, 16, 16'h0864};
        vecs[5] = '{16'h0400, 16'h0000, 2'd1,  0, 16'd2098};
        vecs[6] = '{16'h0400, 16'h4000, 2'd0,  0, 16'd4093};
        vecs[7] = '{16'h0400, 16'h0000, 2'd3,  0, 16'd2060};
        vecs[8] = '{16'h0400, 16'h0000, 2'd2,  8, 16'd2022};

        rst_n = 1'b0; start = 1'b0; stop = 1'b0; m_ready = 1'b1;
        step = '0; phase_offset = '0; amp_shift = '0; burst_len = '0;
        repeat (3) tick();
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_valid", 64'(m_valid), 64'd0);
        check("reset_data", m_data, 64'd0);
        rst_n = 1'b1;
        repeat (4) tick();

        // Latency of the first beat and its lane 0 value.
        configure(16'h0400, 16'h0000, 2'd0, 16'd20, 20);
        pulse_start();
        check("busy_after_start", 64'(busy), 64'd1);
        tick(); tick();
        check("latency_early_valid", 64'(m_valid), 64'd0);
        tick();
        check("latency_first_valid", 64'(m_valid), 64'd1);
        check("first_lane0", 64'(m_data[63:48]), 64'h864);
        wait_done(60, "burst20_done");
        check("burst20_count", 64'(rx_q.size()), 64'd20);
        tick();

        // Table-driven spot values of lane 0 at selected beats.
        for (int v = 0; v < 9; v++) begin
            configure(vecs[v].st, vecs[v].off, vecs[v].sh, 16'(vecs[v].beat + 1), vecs[v].beat + 1);
            pulse_start();
            wait_done(vecs[v].beat + 30, "vec_done");
            got = (rx_q.size() > vecs[v].beat) ? rx_q[vecs[v].beat] : 64'hFFFF_FFFF_FFFF_FFFF;
            check($sformatf("vec%0d_lane0", v), 64'(got[63:48]), 64'(vecs[v].lane0));
            check($sformatf("vec%0d_count", v), 64'(rx_q.size()), 64'(vecs[v].beat + 1));
            tick();
        end

        // Burst of 3: done exactly after the third handshake, then silence.
        configure(16'h0400, 16'h0000, 2'd0, 16'd3, 3);
        pulse_start();
        c = 0;
        while (!done && c < 20) begin tick(); c++; end
        check("burst3_done_cycle", 64'(c), 64'd6);
        check("burst3_count", 64'(rx_q.size()), 64'd3);
        check("burst3_busy_low", 64'(busy), 64'd0);
        check("burst3_valid_low", 64'(m_valid), 64'd0);
        tick();
        check("burst3_done_single", 64'(done), 64'd0);
        repeat (5) tick();
        check("burst3_no_more_valid", 64'(m_valid), 64'd0);

        // Continuous run with a 5-cycle stall, then stop and a start during drain.
        configure(16'h0400, 16'h0000, 2'd0, 16'd0, 64);
        pulse_start();
        wait_rx(5, 30, "cont_reach5");
        m_ready = 1'b0;
        held_exp = model_beat(16'h0000, 16'h0400, 2'd0, rx_q.size());
        for (int s = 0; s < 5; s++) begin
            tick();
            check($sformatf("stall%0d_valid", s), 64'(m_valid), 64'd1);
            check($sformatf("stall%0d_data", s), m_data, held_exp);
        end
        m_ready = 1'b1;
        wait_rx(20, 40, "cont_reach20");
        stop = 1'b1;
        tick();
        stop = 1'b0;
        rx_at_stop = rx_q.size();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(10, "stop_done");
        check("stop_drain_le3", 64'((rx_q.size() - rx_at_stop) <= 3), 64'd1);
        check("stop_drain_ge1", 64'((rx_q.size() - rx_at_stop) >= 1), 64'd1);
        repeat (6) tick();
        check("drain_start_ignored_busy", 64'(busy), 64'd0);
        check("drain_start_ignored_valid", 64'(m_valid), 64'd0);
        exp_q.delete();

        // Reset in the middle of a burst.
        configure(16'h0400, 16'h0000, 2'd0, 16'd10, 10);
        pulse_start();
        wait_rx(2, 30, "rst_reach2");
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_valid", 64'(m_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_data", m_data, 64'd0);
        dc = done_cnt;
        exp_q.delete();
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (4) tick();
        check("rst_no_done", 64'(done_cnt), 64'(dc));
        configure(16'h0400, 16'h0000, 2'd0, 16'd2, 2);
        pulse_start();
        wait_done(20, "after_rst_done");
        check("after_rst_count", 64'(rx_q.size()), 64'd2);
        got = (rx_q.size() > 0) ? rx_q[0] : 64'hFFFF_FFFF_FFFF_FFFF;
        check("after_rst_lane0", 64'(got[63:48]), 64'h864);
        repeat (3) tick();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
